// File: rtl/alu_pipe_flags.sv
// Single-entry registered ALU stage with valid/ready handshake, an architectural
// carry register for multi-transaction ADC/SBC chains, and optional signed saturation.
module alu_pipe_flags #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             carry_q
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned EW  = WIDTH + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ADC = 3'd2,
    OP_SBC = 3'd3,
    OP_ABS = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  op_e             op;
  logic            cin;
  logic            accept;
  logic [EW-1:0]   ext;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res_c;
  logic            c_c;
  logic            v_c;
  logic            neg_true;

  assign op       = op_e'(alu_op);
  assign cin      = carry_clr ? 1'b0 : carry_q;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Datapath: raw result, carry/borrow, signed overflow, then optional clamp.
  always_comb begin
    ext      = '0;
    raw      = '0;
    c_c      = 1'b0;
    v_c      = 1'b0;
    neg_true = a[MSB];
    res_c    = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        ext = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? EW'(cin) : EW'(0));
        raw = ext[WIDTH-1:0];
        c_c = ext[WIDTH];
        v_c = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        ext = {1'b0, a} - {1'b0, b} - ((op == OP_SBC) ? EW'(cin) : EW'(0));
        raw = ext[WIDTH-1:0];
        c_c = ext[WIDTH];
        v_c = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
      end
      OP_ABS: begin
        raw      = a[MSB] ? (~a + WIDTH'(1)) : a;
        v_c      = (a == MIN_NEG);
        neg_true = 1'b0;
      end
      OP_AND: raw = a & b;
      OP_OR:  raw = a | b;
      OP_XOR: raw = a ^ b;
    endcase
    res_c = raw;
    // On overflow the true result has the sign of a (ABS is always positive).
    if (SAT_EN && v_c) begin
      res_c = neg_true ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      carry_q   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= res_c;
      flags     <= {c_c, v_c, (res_c == '0), res_c[MSB]};
      carry_q   <= c_c;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (carry_clr) begin
        carry_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Directed bench for alu_pipe_flags: one wrapping and one saturating instance
// share the same stimulus and are checked against hand-computed values.
module tb_alu_pipe_flags;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADC = 3'd2, SBC = 3'd3,
                         ABS = 3'd4, AND = 3'd5, OR = 3'd6, XOR = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic [2:0] alu_op;
  logic       carry_clr;
  logic       out_ready;

  logic       in_ready, out_valid, carry_q;
  logic [7:0] result;
  logic [3:0] flags;
  logic       s_in_ready, s_out_valid, s_carry_q;
  logic [7:0] s_result;
  logic [3:0] s_flags;

  int n_checks = 0;
  int n_fails  = 0;
  int n_acc    = 0;
  int n_hand   = 0;
  int acc0, hand0;

  always #5 clk = ~clk;

  alu_pipe_flags #(.WIDTH(8), .SAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .carry_clr(carry_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .carry_q(carry_q)
  );

  alu_pipe_flags #(.WIDTH(8), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .alu_op(alu_op), .carry_clr(carry_clr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .flags(s_flags), .carry_q(s_carry_q)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   n_acc  <= n_acc + 1;
      if (out_valid && out_ready) n_hand <= n_hand + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One accepted op with downstream ready; returns #1 after the accepting edge.
  task automatic do_op(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic clr);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = op;
    a         = va;
    b         = vb;
    carry_clr = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    carry_clr = 1'b0;
  endtask

  // flags are {C,V,Z,N}
  task automatic check_op(input string tag, input logic [7:0] r, input logic [3:0] f,
                          input logic [7:0] rs, input logic [3:0] fs, input logic c);
    check_eq({tag, " valid"},      32'(out_valid), 32'd1);
    check_eq({tag, " result"},     32'(result), 32'(r));
    check_eq({tag, " flags"},      32'(flags), 32'(f));
    check_eq({tag, " carry_q"},    32'(carry_q), 32'(c));
    check_eq({tag, " sat result"}, 32'(s_result), 32'(rs));
    check_eq({tag, " sat flags"},  32'(s_flags), 32'(fs));
    check_eq({tag, " sat carry"},  32'(s_carry_q), 32'(c));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = ADD;
    carry_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset result",    32'(result), 32'd0);
    check_eq("reset flags",     32'(flags), 32'd0);
    check_eq("reset carry_q",   32'(carry_q), 32'd0);
    check_eq("reset in_ready",  32'(in_ready), 32'd1);

    do_op(ADD, 8'h7F, 8'h01, 1'b0); check_op("add ovf",   8'h80, 4'b0101, 8'h7F, 4'b0100, 1'b0);
    do_op(ADD, 8'hFF, 8'h01, 1'b0); check_op("add carry", 8'h00, 4'b1010, 8'h00, 4'b1010, 1'b1);
    do_op(ADC, 8'h00, 8'h00, 1'b0); check_op("adc cin",   8'h01, 4'b0000, 8'h01, 4'b0000, 1'b0);
    do_op(ADD, 8'hFF, 8'h01, 1'b0); check_op("add carry2", 8'h00, 4'b1010, 8'h00, 4'b1010, 1'b1);
    do_op(ADC, 8'h00, 8'h00, 1'b1); check_op("adc clr",   8'h00, 4'b0010, 8'h00, 4'b0010, 1'b0);
    do_op(SUB, 8'h00, 8'h01, 1'b0); check_op("sub borrow", 8'hFF, 4'b1001, 8'hFF, 4'b1001, 1'b1);
    do_op(SBC, 8'h05, 8'h02, 1'b0); check_op("sbc bin",   8'h02, 4'b0000, 8'h02, 4'b0000, 1'b0);
    do_op(SUB, 8'h80, 8'h01, 1'b0); check_op("sub ovf",   8'h7F, 4'b0100, 8'h80, 4'b0101, 1'b0);
    do_op(ADD, 8'hFF, 8'h01, 1'b0);
    do_op(ADC, 8'h7F, 8'h00, 1'b0); check_op("adc ovf",   8'h80, 4'b0101, 8'h7F, 4'b0100, 1'b0);
    do_op(ABS, 8'h80, 8'h00, 1'b0); check_op("abs min",   8'h80, 4'b0101, 8'h7F, 4'b0100, 1'b0);
    do_op(ADD, 8'hFF, 8'h01, 1'b0);
    do_op(ABS, 8'hFB, 8'h00, 1'b0); check_op("abs neg",   8'h05, 4'b0000, 8'h05, 4'b0000, 1'b0);
    do_op(AND, 8'hF0, 8'h3C, 1'b0); check_op("and",       8'h30, 4'b0000, 8'h30, 4'b0000, 1'b0);
    do_op(OR,  8'h81, 8'h02, 1'b0); check_op("or",        8'h83, 4'b0001, 8'h83, 4'b0001, 1'b0);
    do_op(XOR, 8'hAA, 8'hAA, 1'b0); check_op("xor zero",  8'h00, 4'b0010, 8'h00, 4'b0010, 1'b0);

    // carry_clr with no accept clears the carry register
    do_op(ADD, 8'hFF, 8'h01, 1'b0);
    check_eq("pre clr carry", 32'(carry_q), 32'd1);
    @(negedge clk); carry_clr = 1'b1;
    @(posedge clk); #1 carry_clr = 1'b0;
    check_eq("idle clr carry", 32'(carry_q), 32'd0);
    check_eq("idle clr result", 32'(result), 32'h00);

    // Backpressure: ADD held three cycles, then hand-off and XOR accept together
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp idle", 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; alu_op = ADD; a = 8'h03; b = 8'h04;
    acc0 = n_acc; hand0 = n_hand;
    @(posedge clk);
    #1;
    alu_op = XOR; a = 8'hF0; b = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp in_ready", 32'(in_ready), 32'd0);
      check_eq("bp hold",     32'(result), 32'h07);
      check_eq("bp valid",    32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp release ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_eq("bp xor result", 32'(result), 32'hFF);
    check_eq("bp xor flags",  32'(flags), 32'b0001);
    check_eq("bp xor valid",  32'(out_valid), 32'd1);
    check_eq("bp handoffs",   32'(n_hand - hand0), 32'd1);
    check_eq("bp accepts",    32'(n_acc - acc0), 32'd2);
    @(posedge clk);
    #1;
    check_eq("bp drain valid",    32'(out_valid), 32'd0);
    check_eq("bp drain handoffs", 32'(n_hand - hand0), 32'd2);

    // Reset during a stall discards the pending result
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; alu_op = ADD; a = 8'hFF; b = 8'h02;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_eq("stall valid", 32'(out_valid), 32'd1);
    check_eq("stall carry", 32'(carry_q), 32'd1);
    check_eq("stall ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst stall valid",  32'(out_valid), 32'd0);
    check_eq("rst stall result", 32'(result), 32'h00);
    check_eq("rst stall flags",  32'(flags), 32'd0);
    check_eq("rst stall carry",  32'(carry_q), 32'd0);
    check_eq("rst stall ready",  32'(in_ready), 32'd1);
    check_eq("rst stall sat valid", 32'(s_out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe_flags.md
Name: alu_pipe_flags

Overview:
Parametrised successor to the team's 8-bit combinational flag ALU. It is WIDTH-generic, registered, and uses a valid/ready handshake on both sides. It keeps an architectural carry register so ADC/SBC chains can span multiple transactions, and it supports optional signed saturation. It sits between the operand-fetch stage and result writeback as a single-entry, 1-cycle-latency execution stage.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SAT_EN, 0, 1 = signed saturation on ADD/SUB/ADC/SBC/ABS overflow; 0 = wrap

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand/op presented
in_ready  out  1  stage can accept
a  in  WIDTH  operand A
b  in  WIDTH  operand B
alu_op  in  3  0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 ABS(a), 5 AND, 6 OR, 7 XOR
carry_clr  in  1  force carry-in of this cycle's op to 0 and clear carry register
out_valid  out  1  result/flags valid
out_ready  in  1  downstream accepts
result  out  WIDTH  registered result
flags  out  4  registered {C,V,Z,N} = flags[3:0]
carry_q  out  1  current architectural carry register

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values: out_valid=0, result=0, flags=0, carry_q=0. in_ready=1 in the cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready.
  - Output hand-off occurs when out_valid && out_ready.
- Output register:
  - On accept: load result/flags and set out_valid=1. Latency is exactly 1 cycle.
  - Hand-off without a new accept: out_valid<=0.
  - Simultaneous hand-off and accept: reload the register, out_valid stays 1, no bubble.
- While out_valid && !out_ready: result, flags and out_valid hold stable. in_ready=0 and inputs are ignored.
- Carry-in: cin = carry_clr ? 0 : carry_q, sampled in the accept cycle.
- Arithmetic: computed at WIDTH+1 bits. C = bit WIDTH of the unsigned result.
  - ADD: a+b. C = carry-out.
  - SUB: a-b. C = borrow (1 iff a<b unsigned).
  - ADC: a+b+cin. C = carry-out.
  - SBC: a-b-cin. C = borrow.
  - V = signed overflow: operand signs agree (ADD/ADC) or differ (SUB/SBC), and the result sign differs from a.
- ABS: result = a[MSB] ? -a : a. C=0. V=1 only for a = most-negative value, where the result is unchanged 100..0.
- AND/OR/XOR: bitwise. C=0, V=0.
- Saturation (SAT_EN=1), applied only when V=1:
  - Clamp to 011..1 if the true result is positive, 100..0 if negative.
  - ABS of most-negative gives 011..1.
  - V remains 1. C is unaffected by saturation.
- Z = (final result == 0), N = final result[MSB]. Both are computed after saturation.
- carry_q updates only on accept:
  - carry_q <= C of the accepted op. Logic ops and ABS therefore clear it.
  - carry_clr without an accept: carry_q <= 0.
  - carry_clr with an accept: cin=0, then carry_q <= the new C.
- alu_op is fully decoded; there are no illegal encodings.
- rst asserted mid-transaction (including during backpressure): the pending result is discarded and all registers take their reset values next edge.
- Flags are never updated without a corresponding accepted result.

Test Plan:
- ADD with WIDTH=8, SAT_EN=0: a=0x7F, b=0x01 -> result 0x80, flags C0 V1 Z0 N1 one cycle after accept. Same stimulus with SAT_EN=1 -> 0x7F, C0 V1 Z0 N0.
- Carry chain: ADD 0xFF+0x01 -> 0x00, C1 V0 Z1 N0, carry_q=1. Then ADC 0x00+0x00 -> 0x01, carry_q=0. Repeat the ADC with carry_clr=1 -> 0x00, Z1.
- SUB 0x00-0x01 -> 0xFF, C1 V0 Z0 N1. Then SBC 0x05-0x02 with carry_q=1 -> 0x02, C0.
- ABS a=0x80 -> 0x80, V1 N1 (SAT_EN=0) or 0x7F, V1 N0 (SAT_EN=1). ABS a=0xFB -> 0x05, V0.
- Backpressure: accept ADD 3+4, hold out_ready=0 for 3 cycles while in_valid=1 with XOR 0xF0^0x0F. Required:
  - in_ready=0 and result holds 0x07 during the stall.
  - On out_ready=1, the 0x07 transfer and the XOR accept occur in the same cycle.
  - Next cycle result=0xFF, N1. No transaction lost or duplicated.
- Reset mid-stall: out_valid=1 and out_ready=0, assert rst one cycle -> out_valid=0, result=0x00, flags=0, carry_q=0, in_ready=1 after release.
